core_hazard_ctrl: RTL and testbench

CORE_HAZARD_CTRL -- requirements
Module: core_hazard_ctrl

---
 rtl/core_hazard_ctrl_pkg.sv | 53 +++++
 rtl/core_hazard_ctrl_md_countdown.sv | 44 ++++
 rtl/core_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_core_hazard_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_hazard_ctrl_pkg
// Purpose : Shared pipeline structures for the core. Holds the hazard FSM
//           state type, the pipeline-register typedefs, the default mul/div
//           occupancy and the load-use hazard predicate.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package core_hazard_ctrl_pkg;

  // Default number of cycles a mul/div op holds the HI/LO unit.
  localparam int c_MD_LATENCY_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_WAIT   = 2'd1,
    EXC_DRAIN = 2'd2
  } hazard_state_t;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_regs_t;

  // ID/EX pipeline register contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  w_regnum;
    logic        is_load;
    logic        muldiv;
    logic        valid;
  } id_ex_regs_t;

  // A load in EX whose destination is consumed by the instruction in ID.
  // $zero is never a real dependency.
  function automatic logic load_use_hazard(
    input logic       ex_load,
    input logic [4:0] ex_w_regnum,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_b_is_reg
  );
    return ex_load && (ex_w_regnum != 5'd0) &&
           ((ex_w_regnum == id_rs) || (id_b_is_reg && (ex_w_regnum == id_rt)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_hazard_ctrl_md_countdown.sv
`default_nettype none
// ============================================================================
// Module  : md_countdown
// Purpose : Occupancy counter for the mul/div unit. Loads a start value,
//           counts down one per enabled cycle and saturates at zero.
// Ports   : clock, reset        - clock, asynchronous active-high reset
//           i_load, i_load_value - load the counter (wins over decrement)
//           i_dec                - decrement by one, never below zero
//           i_clear              - force the counter to zero (highest priority)
//           o_zero               - counter currently equals zero
// Revision: 1.0 - initial release
// ============================================================================
module md_countdown
  import core_hazard_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  input  logic             i_clear,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/core_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : core_hazard_ctrl
// Purpose : Pipeline hazard controller. Resolves exceptions/ERET, taken
//           branches, the HI/LO mul/div interlock and load-use hazards into
//           stall, flush and mul/div control for the IF, ID and EX stages.
// Ports   : clock, reset                 - clock, async active-high reset
//           i_id_rs, i_id_rt             - ID source register numbers
//           i_id_B_is_reg                - ID reads rt as a register
//           i_id_muldiv, i_id_reads_hilo - ID starts mul/div / reads HI/LO
//           i_ex_load, i_ex_W_regnum     - EX load flag and destination
//           i_ex_branch_taken            - EX resolved a taken branch/jump
//           i_mem_exception, i_mem_eret  - MEM exception / ERET
//           o_if_stall, o_id_stall       - hold PC+IF / bubble into ID_regs
//           o_id_flush, o_ex_flush       - clear ID / EX pipeline register
//           o_md_start, o_md_abort       - launch / cancel mul/div pulses
//           o_md_busy                    - registered, high in MD_WAIT
//           o_redirect                   - PC takes vector or EPC
// Revision: 1.0 - initial release
// ============================================================================
module core_hazard_ctrl
  import core_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = c_MD_LATENCY_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_B_is_reg,
  input  logic       i_id_muldiv,
  input  logic       i_id_reads_hilo,
  input  logic       i_ex_load,
  input  logic [4:0] i_ex_W_regnum,
  input  logic       i_ex_branch_taken,
  input  logic       i_mem_exception,
  input  logic       i_mem_eret,
  output logic       o_if_stall,
  output logic       o_id_stall,
  output logic       o_id_flush,
  output logic       o_ex_flush,
  output logic       o_md_start,
  output logic       o_md_abort,
  output logic       o_md_busy,
  output logic       o_redirect
);

  localparam int                 c_CNT_W = $clog2(MD_LATENCY);
  localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(MD_LATENCY - 1);

  hazard_state_t r_state;
  hazard_state_t w_next_state;
  logic          r_md_busy;

  logic w_load_use;
  logic w_exc;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_clear;
  logic w_cnt_zero;

  logic w_if_stall;
  logic w_id_stall;
  logic w_id_flush;
  logic w_ex_flush;
  logic w_md_start;
  logic w_md_abort;
  logic w_redirect;

  assign w_load_use = load_use_hazard(i_ex_load, i_ex_W_regnum, i_id_rs,
                                      i_id_rt, i_id_B_is_reg);
  assign w_exc      = i_mem_exception | i_mem_eret;

  md_countdown #(
    .WIDTH (c_CNT_W)
  ) u_md_countdown (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_cnt_load),
    .i_load_value (c_LOAD),
    .i_dec        (w_cnt_dec),
    .i_clear      (w_cnt_clear),
    .o_zero       (w_cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_md_busy <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_md_busy <= (w_next_state == MD_WAIT);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_if_stall   = 1'b0;
    w_id_stall   = 1'b0;
    w_id_flush   = 1'b0;
    w_ex_flush   = 1'b0;
    w_md_start   = 1'b0;
    w_md_abort   = 1'b0;
    w_redirect   = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_cnt_clear  = 1'b0;

    // Outputs are held low for the whole reset assertion; the registers are
    // already being forced asynchronously.
    if (!reset) begin
      unique case (r_state)
        RUN: begin
          if (w_exc) begin
            w_redirect   = 1'b1;
            w_id_flush   = 1'b1;
            w_ex_flush   = 1'b1;
            w_next_state = EXC_DRAIN;
          end else if (i_ex_branch_taken) begin
            // Flush wins over any stall, including a coincident load-use.
            w_id_flush = 1'b1;
          end else if (w_load_use) begin
            w_if_stall = 1'b1;
            w_id_stall = 1'b1;
          end else if (i_id_muldiv) begin
            w_md_start   = 1'b1;
            w_cnt_load   = 1'b1;
            w_next_state = MD_WAIT;
          end
        end

        MD_WAIT: begin
          w_cnt_dec = 1'b1;
          if (w_exc) begin
            w_redirect   = 1'b1;
            w_id_flush   = 1'b1;
            w_ex_flush   = 1'b1;
            w_md_abort   = 1'b1;
            w_cnt_clear  = 1'b1;
            w_next_state = EXC_DRAIN;
          end else begin
            if (i_ex_branch_taken) begin
              w_id_flush = 1'b1;
            end else if (i_id_muldiv || (i_id_reads_hilo && !w_cnt_zero)) begin
              // A new mul/div waits for the unit to go idle and issues from
              // RUN. A HI/LO read is released in the final busy cycle, when
              // the unit's result is already committed, so it reaches EX
              // just as the state returns to RUN.
              w_if_stall = 1'b1;
              w_id_stall = 1'b1;
            end else if (w_load_use) begin
              w_if_stall = 1'b1;
              w_id_stall = 1'b1;
            end
            if (w_cnt_zero) begin
              w_next_state = RUN;
            end
          end
        end

        EXC_DRAIN: begin
          if (w_exc) begin
            w_redirect   = 1'b1;
            w_id_flush   = 1'b1;
            w_ex_flush   = 1'b1;
            w_next_state = EXC_DRAIN;
          end else begin
            w_id_flush   = 1'b1;
            w_next_state = RUN;
          end
        end

        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

  assign o_if_stall = w_if_stall;
  assign o_id_stall = w_id_stall;
  assign o_id_flush = w_id_flush;
  assign o_ex_flush = w_ex_flush;
  assign o_md_start = w_md_start;
  assign o_md_abort = w_md_abort;
  assign o_redirect = w_redirect;
  assign o_md_busy  = r_md_busy;

endmodule
`default_nettype wire

// File: tb/tb_core_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_hazard_ctrl
// Purpose : Self-checking bench for core_hazard_ctrl (MD_LATENCY = 4).
//           Directed scenarios followed by randomized traffic compared with a
//           cycle-level behavioural model of the hazard rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_hazard_ctrl;

  localparam int LAT = 4;

  // Output vector bit order: if_stall id_stall id_flush ex_flush md_start md_abort redirect
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_STALL = 7'b1100000;
  localparam logic [6:0] O_IDF   = 7'b0010000;
  localparam logic [6:0] O_START = 7'b0000100;
  localparam logic [6:0] O_EXC   = 7'b0011001;
  localparam logic [6:0] O_EXCAB = 7'b0011011;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_W;
  logic       id_B_is_reg, id_muldiv, id_reads_hilo, ex_load;
  logic       ex_branch_taken, mem_exception, mem_eret;
  logic       if_stall, id_stall, id_flush, ex_flush;
  logic       md_start, md_abort, md_busy, redirect;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  // Model state: remaining busy cycles of the HI/LO unit, and drain flag.
  int m_busy_left;
  bit m_drain;

  always #5 clock = ~clock;

  assign obs = {if_stall, id_stall, id_flush, ex_flush, md_start, md_abort, redirect};

  core_hazard_ctrl #(
    .MD_LATENCY (LAT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_B_is_reg     (id_B_is_reg),
    .i_id_muldiv       (id_muldiv),
    .i_id_reads_hilo   (id_reads_hilo),
    .i_ex_load         (ex_load),
    .i_ex_W_regnum     (ex_W),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mem_exception   (mem_exception),
    .i_mem_eret        (mem_eret),
    .o_if_stall        (if_stall),
    .o_id_stall        (id_stall),
    .o_id_flush        (id_flush),
    .o_ex_flush        (ex_flush),
    .o_md_start        (md_start),
    .o_md_abort        (md_abort),
    .o_md_busy         (md_busy),
    .o_redirect        (redirect)
  );

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_W = 5'd0;
    id_B_is_reg = 1'b0; id_muldiv = 1'b0; id_reads_hilo = 1'b0; ex_load = 1'b0;
    ex_branch_taken = 1'b0; mem_exception = 1'b0; mem_eret = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Expected outputs straight from the priority rules.
  function automatic logic [6:0] model_out();
    logic [6:0] e;
    bit lu;
    bit exc;
    e   = O_NONE;
    lu  = ex_load && (ex_W != 0) && ((ex_W == id_rs) || (id_B_is_reg && (ex_W == id_rt)));
    exc = mem_exception || mem_eret;
    if (exc) e = {4'b0011, 1'b0, (m_busy_left > 0), 1'b1};
    else if (m_drain) e = O_IDF;
    else if (ex_branch_taken) e = O_IDF;
    else if ((m_busy_left > 0) && (id_muldiv || (id_reads_hilo && (m_busy_left > 1)))) e = O_STALL;
    else if (lu) e = O_STALL;
    else if ((m_busy_left == 0) && id_muldiv) e = O_START;
    return e;
  endfunction

  task automatic model_advance(input logic [6:0] e, input bit exc);
    if (exc) begin
      m_drain = 1'b1;
      m_busy_left = 0;
    end else if (m_drain) begin
      m_drain = 1'b0;
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (e[2]) m_busy_left = LAT;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    mem_exception = 1'b1; id_muldiv = 1'b1; ex_load = 1'b1; ex_W = 5'd8; id_rs = 5'd8;
    #2;
    checks++;
    if (obs !== O_NONE || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b busy=%b, want %b busy=0", obs, md_busy, O_NONE);
    end
    next_cycle();
    checks++;
    if (obs !== O_NONE || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got %b busy=%b, want %b busy=0", obs, md_busy, O_NONE);
    end
    set_idle();
    @(negedge clock);
    reset = 1'b0;
    next_cycle();
    @(negedge clock);
    checks++;
    if (obs !== O_NONE || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b busy=%b, want %b busy=0", obs, md_busy, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_load = 1'b1; ex_W = 5'd8; id_rs = 5'd8; id_rt = 5'd10; id_B_is_reg = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_STALL) begin
      errors++;
      $display("FAIL load_use_rs: got %b, want %b", obs, O_STALL);
    end
    next_cycle();
    // Load has moved to MEM, a bubble sits in EX; same consumer in ID.
    ex_load = 1'b0; ex_W = 5'd0;
    @(negedge clock);
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL load_use_one_cycle: got %b, want %b", obs, O_NONE);
    end
    next_cycle();
    // Hazard through rt, only when rt is a register operand.
    ex_load = 1'b1; ex_W = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_B_is_reg = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_STALL) begin
      errors++;
      $display("FAIL load_use_rt: got %b, want %b", obs, O_STALL);
    end
    next_cycle();
    id_B_is_reg = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL load_use_rt_imm: got %b, want %b", obs, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_zero_dest();
    set_idle();
    ex_load = 1'b1; ex_W = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_B_is_reg = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL zero_dest: got %b, want %b", obs, O_NONE);
    end
    next_cycle();
    ex_load = 1'b0; ex_W = 5'd8; id_rs = 5'd8;
    @(negedge clock);
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL non_load_dep: got %b, want %b", obs, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_muldiv_interlock();
    int stalls = 0;
    int busy = 0;
    set_idle();
    id_muldiv = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_START || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_issue: got %b busy=%b, want %b busy=0", obs, md_busy, O_START);
    end
    next_cycle();
    id_muldiv = 1'b0; id_reads_hilo = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      if (md_busy === 1'b1) busy++;
      if (obs === O_STALL) stalls++;
      checks++;
      if (obs !== ((k < LAT - 1) ? O_STALL : O_NONE)) begin
        errors++;
        $display("FAIL mflo_interlock k=%0d: got %b, want %b", k, obs,
                 (k < LAT - 1) ? O_STALL : O_NONE);
      end
      next_cycle();
      // Once released the mflo leaves ID.
      if (obs !== O_STALL) id_reads_hilo = 1'b0;
    end
    set_idle();
    @(negedge clock);
    checks++;
    if (busy != LAT || stalls != LAT - 1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_counts: busy=%0d stalls=%0d busy_now=%b, want busy=%0d stalls=%0d busy_now=0",
               busy, stalls, md_busy, LAT, LAT - 1);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    set_idle();
    id_muldiv = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_START) begin
      errors++;
      $display("FAIL b2b_first: got %b, want %b", obs, O_START);
    end
    next_cycle();
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== O_STALL || md_busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_held k=%0d: got %b busy=%b, want %b busy=1", k, obs, md_busy, O_STALL);
      end
      next_cycle();
    end
    @(negedge clock);
    checks++;
    if (obs !== O_START || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got %b busy=%b, want %b busy=0", obs, md_busy, O_START);
    end
    next_cycle();
    set_idle();
    @(negedge clock);
    checks++;
    if (md_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_busy: got %b, want 1", md_busy);
    end
    idle_cycles(LAT + 1);
  endtask

  task automatic test_exc_in_wait();
    set_idle();
    id_muldiv = 1'b1;
    next_cycle();           // issue; counter now 3
    set_idle();
    next_cycle();           // counter now 2
    mem_exception = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_EXCAB || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL exc_in_wait: got %b busy=%b, want %b busy=1", obs, md_busy, O_EXCAB);
    end
    next_cycle();
    mem_exception = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== O_IDF || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL exc_drain: got %b busy=%b, want %b busy=0", obs, md_busy, O_IDF);
    end
    next_cycle();
    id_muldiv = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_START || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL exc_back_to_run: got %b busy=%b, want %b busy=0", obs, md_busy, O_START);
    end
    next_cycle();
    idle_cycles(LAT + 1);
    // ERET from RUN: redirect without abort, then one drain cycle.
    mem_eret = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_EXC) begin
      errors++;
      $display("FAIL eret_run: got %b, want %b", obs, O_EXC);
    end
    next_cycle();
    mem_eret = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== O_IDF) begin
      errors++;
      $display("FAIL eret_drain: got %b, want %b", obs, O_IDF);
    end
    next_cycle();
  endtask

  task automatic test_branch_vs_load_use();
    set_idle();
    ex_branch_taken = 1'b1; ex_load = 1'b1; ex_W = 5'd8; id_rs = 5'd8;
    @(negedge clock);
    checks++;
    if (obs !== O_IDF) begin
      errors++;
      $display("FAIL branch_vs_load_use: got %b, want %b", obs, O_IDF);
    end
    next_cycle();
    set_idle();
    ex_branch_taken = 1'b1; id_muldiv = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== O_IDF) begin
      errors++;
      $display("FAIL branch_vs_muldiv: got %b, want %b", obs, O_IDF);
    end
    next_cycle();
    set_idle();
    @(negedge clock);
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL branch_no_issue_busy: got %b, want 0", md_busy);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    set_idle();
    id_muldiv = 1'b1;
    next_cycle();
    set_idle();
    id_reads_hilo = 1'b1;
    mem_exception = 1'b0;
    #2;
    checks++;
    if (obs !== O_STALL || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_wait: got %b busy=%b, want %b busy=1", obs, md_busy, O_STALL);
    end
    mem_exception = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== O_NONE || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %b busy=%b, want %b busy=0", obs, md_busy, O_NONE);
    end
    reset = 1'b0;
    set_idle();
    id_muldiv = 1'b1;
    #2;
    checks++;
    if (obs !== O_START || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_async_reset: got %b busy=%b, want %b busy=0", obs, md_busy, O_START);
    end
    next_cycle();
    idle_cycles(LAT + 1);
  endtask

  task automatic test_random();
    logic [6:0] e;
    bit exc;
    set_idle();
    reset = 1'b1;
    next_cycle();
    @(negedge clock);
    reset = 1'b0;
    m_busy_left = 0;
    m_drain = 1'b0;
    next_cycle();
    for (int c = 0; c < 600; c++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_W            = 5'($urandom_range(0, 3));
      id_B_is_reg     = 1'($urandom_range(0, 1));
      ex_load         = 1'($urandom_range(0, 1));
      id_muldiv       = ($urandom_range(0, 99) < 30);
      id_reads_hilo   = ($urandom_range(0, 99) < 30);
      ex_branch_taken = ($urandom_range(0, 99) < 12);
      mem_exception   = ($urandom_range(0, 99) < 4);
      mem_eret        = ($urandom_range(0, 99) < 3);
      @(negedge clock);
      e = model_out();
      exc = mem_exception || mem_eret;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random_outputs cycle %0d: got %b, want %b", c, obs, e);
      end
      checks++;
      if (md_busy !== (m_busy_left > 0)) begin
        errors++;
        $display("FAIL random_busy cycle %0d: got %b, want %b", c, md_busy, (m_busy_left > 0));
      end
      @(posedge clock);
      model_advance(e, exc);
      #1;
    end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_zero_dest();
    test_muldiv_interlock();
    test_back_to_back();
    test_exc_in_wait();
    test_branch_vs_load_use();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
